// File: rtl/packet_arbiter_if.sv
// Bundle of the source-FIFO read port and the serialized output stream that
// connects packet_arbiter to its sources and to the host-link consumer.
interface packet_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC*128-1:0] SRC_FIFO_DATA;
    logic [NUM_SRC-1:0]     SRC_FIFO_EMPTY;
    logic [NUM_SRC-1:0]     SRC_FIFO_READ;
    logic [31:0]            OUT_DATA;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic                   OUT_LAST;
    logic [1:0]             OUT_SRC;
    logic [15:0]            PKT_COUNT;

    // Arbiter side: reads FIFOs, drives the word stream.
    modport master (
        input  SRC_FIFO_DATA, SRC_FIFO_EMPTY, OUT_READY,
        output SRC_FIFO_READ, OUT_DATA, OUT_VALID, OUT_LAST, OUT_SRC, PKT_COUNT
    );

    // Environment side: FIFOs and the word-stream consumer.
    modport slave (
        output SRC_FIFO_DATA, SRC_FIFO_EMPTY, OUT_READY,
        input  SRC_FIFO_READ, OUT_DATA, OUT_VALID, OUT_LAST, OUT_SRC, PKT_COUNT
    );
endinterface

// File: rtl/packet_arbiter.sv
// Round-robin arbiter over up to four standard-read source FIFOs. Each
// selected 128-bit packet is read once, captured, and sent as four 32-bit
// words (header first, timestamp last) on a valid/ready stream.
module packet_arbiter #(
    parameter int NUM_SRC = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ARB_ENABLE,
    packet_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_SEND    = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [1:0]           sel_r;
    logic [1:0]           last_served_r;
    logic [1:0]           pick_s;
    logic [3:0]           empty_pad_s;
    logic                 any_s;
    logic                 go_s;
    logic                 accept_s;
    logic                 done_s;
    logic [127:0]         src_word_s [4];
    logic [127:0]         cap_s;
    logic [127:0]         shift_r;
    logic [1:0]           idx_r;
    logic [NUM_SRC-1:0]   read_r;
    logic [31:0]          out_data_r;
    logic                 out_valid_r;
    logic                 out_last_r;
    logic [1:0]           out_src_r;
    logic [15:0]          pkt_count_r;

    // First non-empty source after 'last' in circular order; only called when
    // at least one source is non-empty, so the fallback value is never used.
    function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                           input logic [3:0] empty_mask);
        logic [1:0] pick_v;
        logic       found_v;
        int         cand_v;
        pick_v  = 2'd0;
        found_v = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand_v = (int'(last) + k) % NUM_SRC;
            if (!found_v && !empty_mask[cand_v[1:0]]) begin
                pick_v  = cand_v[1:0];
                found_v = 1'b1;
            end
        end
        return pick_v;
    endfunction

    // Unused source slots look permanently empty and carry zero data.
    for (genvar g = 0; g < 4; g++) begin : g_src
        if (g < NUM_SRC) begin : g_used
            assign empty_pad_s[g] = bus.SRC_FIFO_EMPTY[g];
            assign src_word_s[g]  = bus.SRC_FIFO_DATA[128*g +: 128];
        end else begin : g_unused
            assign empty_pad_s[g] = 1'b1;
            assign src_word_s[g]  = 128'd0;
        end
    end

    assign any_s    = ~&empty_pad_s;
    assign pick_s   = rr_pick(last_served_r, empty_pad_s);
    assign cap_s    = src_word_s[sel_r];
    assign accept_s = (state_r == ST_SEND) && bus.OUT_READY;
    assign done_s   = accept_s && (idx_r == 2'd3);

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; ARB_ENABLE only gates leaving IDLE.
    always_comb begin
        state_nxt_s = state_r;
        go_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ARB_ENABLE && any_s) begin
                    go_s        = 1'b1;
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ:    state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_SEND;
            ST_SEND: begin
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Selection, read strobe, capture/serialize datapath and packet counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sel_r         <= 2'd0;
            last_served_r <= 2'(NUM_SRC - 1);
            read_r        <= '0;
            shift_r       <= 128'd0;
            idx_r         <= 2'd0;
            out_data_r    <= 32'd0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_src_r     <= 2'd0;
            pkt_count_r   <= 16'd0;
        end else begin
            // Strobe is high exactly during READ, for the source picked in IDLE.
            for (int i = 0; i < NUM_SRC; i++) begin
                read_r[i] <= go_s && (pick_s == 2'(i));
            end
            if (go_s) begin
                sel_r <= pick_s;
            end
            case (state_r)
                ST_CAPTURE: begin
                    // FIFO dout became valid on the edge that ended READ.
                    shift_r     <= cap_s;
                    out_data_r  <= cap_s[127:96];
                    out_valid_r <= 1'b1;
                    out_last_r  <= 1'b0;
                    out_src_r   <= sel_r;
                    idx_r       <= 2'd0;
                end
                ST_SEND: begin
                    if (accept_s) begin
                        if (idx_r == 2'd3) begin
                            out_valid_r   <= 1'b0;
                            out_last_r    <= 1'b0;
                            pkt_count_r   <= pkt_count_r + 16'd1;
                            last_served_r <= sel_r;
                        end else begin
                            out_data_r <= shift_r[95:64];
                            shift_r    <= {shift_r[95:0], 32'd0};
                            idx_r      <= idx_r + 2'd1;
                            out_last_r <= (idx_r == 2'd2);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.SRC_FIFO_READ = read_r;
    assign bus.OUT_DATA      = out_data_r;
    assign bus.OUT_VALID     = out_valid_r;
    assign bus.OUT_LAST      = out_last_r;
    assign bus.OUT_SRC       = out_src_r;
    assign bus.PKT_COUNT     = pkt_count_r;

endmodule

// File: tb/tb_packet_arbiter.sv
// Self-checking bench for packet_arbiter: standard-mode FIFO models feed the
// DUT; a transaction-level round-robin model predicts every output word.
module tb_packet_arbiter;

    logic CLK        = 1'b0;
    logic RESET      = 1'b1;
    logic ARB_ENABLE = 1'b0;

    packet_arbiter_if #(.NUM_SRC(4)) bus ();

    packet_arbiter #(.NUM_SRC(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ARB_ENABLE (ARB_ENABLE),
        .bus        (bus)
    );

    // 100 MHz clock.
    always #5 CLK = ~CLK;

    // FIFO contents (hardware side) and model's view of the same packets.
    logic [127:0] fifo_q [4][$];
    logic [127:0] exp_q  [4][$];
    logic [127:0] fifo_dout [4] = '{default: 128'd0};
    logic [3:0]   fifo_empty    = 4'hF;

    assign bus.SRC_FIFO_DATA  = {fifo_dout[3], fifo_dout[2], fifo_dout[1], fifo_dout[0]};
    assign bus.SRC_FIFO_EMPTY = fifo_empty;

    // Standard-mode FIFO: dout updates on the edge that samples rd_en.
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.SRC_FIFO_READ[i] && fifo_q[i].size() > 0) begin
                fifo_dout[i] <= fifo_q[i].pop_front();
            end
            fifo_empty[i] <= (fifo_q[i].size() == 0);
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [1:0]  model_last = 2'd3;
    int          model_cnt  = 0;
    bit          in_pkt     = 1'b0;
    int          widx       = 0;
    logic [31:0] cur_words [4];
    logic [1:0]  cur_src    = 2'd0;

    bit          prev_strobe  = 1'b0;
    bit          stalled_prev = 1'b0;
    bit          en_sampled   = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic [1:0]  held_src;

    int          rd_cnt [4] = '{default: 0};
    int          last_strobe_cyc = 0;
    int          first_cyc = 0;
    int          last_cyc  = 0;
    int          strobe_log [$];
    logic [1:0]  src_log [$];
    logic [31:0] w_log [$];

    int          ready_mode = 0;
    int          stall_cnt  = 0;
    bit          en_val     = 1'b1;
    bit          en_rand    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int s, input logic [127:0] d);
        fifo_q[s].push_back(d);
        exp_q[s].push_back(d);
    endtask

    // Round robin at packet level: next non-empty queue after the last served one.
    task automatic model_pick(output bit ok);
        int c;
        logic [127:0] pkt;
        ok = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            c = (int'(model_last) + k) % 4;
            if (!ok && exp_q[c].size() > 0) begin
                ok      = 1'b1;
                cur_src = 2'(c);
            end
        end
        if (ok) begin
            pkt          = exp_q[cur_src].pop_front();
            cur_words[0] = pkt[127:96];
            cur_words[1] = pkt[95:64];
            cur_words[2] = pkt[63:32];
            cur_words[3] = pkt[31:0];
        end
    endtask

    function automatic bit model_idle();
        return !in_pkt && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
               exp_q[2].size() == 0 && exp_q[3].size() == 0;
    endfunction

    task automatic drive();
        case (ready_mode)
            0: bus.OUT_READY = 1'b1;
            1: bus.OUT_READY = ($urandom_range(0, 2) != 0);
            2: begin
                if (in_pkt && widx == 1 && stall_cnt < 5) begin
                    bus.OUT_READY = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.OUT_READY = 1'b1;
                end
            end
            default: bus.OUT_READY = 1'b1;
        endcase
        ARB_ENABLE = en_rand ? ($urandom_range(0, 4) != 0) : en_val;
    endtask

    // Inspect DUT outputs; a word counts as accepted at the coming posedge.
    task automatic monitor();
        bit ok;
        check("pkt_count", bus.PKT_COUNT, 16'(model_cnt));
        if (bus.SRC_FIFO_READ != 4'd0) begin
            check("rd_onehot", $countones(bus.SRC_FIFO_READ), 1);
            check("rd_while_disabled", en_sampled, 1);
            check("rd_one_cycle", prev_strobe, 0);
            for (int i = 0; i < 4; i++) begin
                if (bus.SRC_FIFO_READ[i]) begin
                    check("rd_nonempty", bus.SRC_FIFO_EMPTY[i], 0);
                    rd_cnt[i]++;
                end
            end
            last_strobe_cyc = cyc;
            strobe_log.push_back(cyc);
        end
        prev_strobe = (bus.SRC_FIFO_READ != 4'd0);
        if (stalled_prev) begin
            check("hold_valid", bus.OUT_VALID, 1);
            check("hold_data", bus.OUT_DATA, held_data);
            check("hold_last", bus.OUT_LAST, held_last);
            check("hold_src", bus.OUT_SRC, held_src);
        end
        stalled_prev = bus.OUT_VALID && !bus.OUT_READY;
        held_data    = bus.OUT_DATA;
        held_last    = bus.OUT_LAST;
        held_src     = bus.OUT_SRC;
        if (bus.OUT_VALID && bus.OUT_READY) begin
            if (!in_pkt) begin
                model_pick(ok);
                if (ok) begin
                    in_pkt    = 1'b1;
                    widx      = 0;
                    first_cyc = cyc;
                end else begin
                    check("spurious_word", 1, 0);
                end
            end
            if (in_pkt) begin
                check("word", bus.OUT_DATA, cur_words[widx]);
                check("last", bus.OUT_LAST, (widx == 3));
                check("src", bus.OUT_SRC, cur_src);
                w_log.push_back(bus.OUT_DATA);
                widx++;
                if (widx == 4) begin
                    in_pkt     = 1'b0;
                    model_cnt  = model_cnt + 1;
                    model_last = cur_src;
                    last_cyc   = cyc;
                    src_log.push_back(cur_src);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        cyc++;
        en_sampled = ARB_ENABLE;
        drive();
        monitor();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!model_idle() && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", (n < budget), 1);
        repeat (3) step();
    endtask

    // Caller positions time away from the rising edge before calling.
    task automatic reset_pulse();
        RESET = 1'b1;
        #1;
        check("rst_valid", bus.OUT_VALID, 0);
        check("rst_pkt_count", bus.PKT_COUNT, 0);
        check("rst_read", bus.SRC_FIFO_READ, 0);
        model_last   = 2'd3;
        model_cnt    = 0;
        in_pkt       = 1'b0;
        stalled_prev = 1'b0;
        prev_strobe  = 1'b0;
        @(negedge CLK);
        #2;
        RESET = 1'b0;
    endtask

    initial begin
        int c0;
        int rd0 [4];
        int rds;
        bus.OUT_READY = 1'b0;

        // Reset values.
        repeat (2) @(negedge CLK);
        check("init_read", bus.SRC_FIFO_READ, 0);
        check("init_valid", bus.OUT_VALID, 0);
        check("init_last", bus.OUT_LAST, 0);
        check("init_data", bus.OUT_DATA, 0);
        check("init_src", bus.OUT_SRC, 0);
        check("init_pkt_count", bus.PKT_COUNT, 0);
        #2;
        RESET = 1'b0;

        // Single packet from source 0.
        ready_mode = 0;
        en_val     = 1'b1;
        push(0, {32'h1000_3400, 32'hdeadbeef, 32'hdeadbeef, 32'h0000_1234});
        drain(60);
        check("sp_reads0", rd_cnt[0], 1);
        check("sp_reads_other", rd_cnt[1] + rd_cnt[2] + rd_cnt[3], 0);
        check("sp_latency", first_cyc - last_strobe_cyc, 2);
        check("sp_span", last_cyc - first_cyc, 3);
        check("sp_src", src_log[0], 0);
        check("sp_w0", w_log[0], 32'h1000_3400);
        check("sp_w1", w_log[1], 32'hdeadbeef);
        check("sp_w3", w_log[3], 32'h0000_1234);

        // Round robin over four sources with two packets each.
        @(negedge CLK);
        #2;
        reset_pulse();
        for (int s = 0; s < 4; s++) rd0[s] = rd_cnt[s];
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 4; s++)
                push(s, {$urandom(), $urandom(), $urandom(), $urandom()});
        src_log.delete();
        strobe_log.delete();
        drain(200);
        check("rr_count", src_log.size(), 8);
        for (int i = 0; i < src_log.size() && i < 8; i++) check("rr_order", src_log[i], i % 4);
        for (int s = 0; s < 4; s++) check("rr_reads", rd_cnt[s] - rd0[s], 2);
        for (int i = 1; i < strobe_log.size(); i++)
            check("rr_gap", strobe_log[i] - strobe_log[i-1], 7);

        // Backpressure: word 1 stalled for five cycles.
        ready_mode = 2;
        stall_cnt  = 0;
        push(0, {$urandom(), $urandom(), $urandom(), $urandom()});
        drain(80);
        check("bp_stalls", stall_cnt, 5);
        check("bp_span", last_cyc - first_cyc, 8);
        check("bp_src", src_log[$], 0);
        ready_mode = 0;

        // Skip empty: serve source 1, then only source 0 is available.
        push(1, {$urandom(), $urandom(), $urandom(), $urandom()});
        drain(60);
        rd0[2] = rd_cnt[2];
        rd0[3] = rd_cnt[3];
        push(0, {$urandom(), $urandom(), $urandom(), $urandom()});
        drain(60);
        check("skip_src", src_log[$], 0);
        check("skip_no_rd2", rd_cnt[2] - rd0[2], 0);
        check("skip_no_rd3", rd_cnt[3] - rd0[3], 0);

        // Enable gating: drop ARB_ENABLE during word 2.
        push(1, {$urandom(), $urandom(), $urandom(), $urandom()});
        push(2, {$urandom(), $urandom(), $urandom(), $urandom()});
        c0 = model_cnt;
        for (int n = 0; n < 40 && !(in_pkt && widx == 2); n++) step();
        en_val = 1'b0;
        rds = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
        repeat (12) step();
        check("en_pkt_done", model_cnt - c0, 1);
        check("en_no_read", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - rds, 0);
        en_val = 1'b1;
        step();
        step();
        check("en_resume", last_strobe_cyc, cyc);
        drain(60);
        check("en_src", src_log[$], 2);

        // Reset after word 1 of a packet from source 3.
        push(3, {$urandom(), $urandom(), $urandom(), $urandom()});
        push(3, {$urandom(), $urandom(), $urandom(), $urandom()});
        push(0, {$urandom(), $urandom(), $urandom(), $urandom()});
        for (int n = 0; n < 40 && !(in_pkt && widx == 2); n++) step();
        @(posedge CLK);
        #2;
        reset_pulse();
        src_log.delete();
        drain(80);
        check("rst_pkts", src_log.size(), 2);
        if (src_log.size() == 2) begin
            check("rst_first_src", src_log[0], 0);
            check("rst_second_src", src_log[1], 3);
        end

        // Randomized rounds: random fill, backpressure and enable.
        ready_mode = 1;
        en_rand    = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 4; s++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++)
                    push(s, {$urandom(), $urandom(), $urandom(), $urandom()});
            end
            drain(600);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

Round-robin arbiter and serializer sitting directly downstream of the error-injection block and its sibling packet sources. It drains 128-bit packets from up to four source FIFOs (standard-read, non-first-word-fall-through), one packet at a time. Each packet goes out as four 32-bit words on a valid/ready stream toward the host-link interface. It owns every source FIFO read strobe, including the error FIFO read.

## Interface

Parameters:
- NUM_SRC, default 4, number of active source FIFOs; legal range 1..4; unused inputs ignored.

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset, asynchronous, active-high
- ARB_ENABLE  in  1  high permits starting new packets
- SRC_FIFO_DATA  in  NUM_SRC*128  source FIFO dout; source i occupies bits [128*i+127 : 128*i]
- SRC_FIFO_EMPTY  in  NUM_SRC  source FIFO empty flags
- SRC_FIFO_READ  out  NUM_SRC  source FIFO rd_en, one-hot, registered
- OUT_DATA  out  32  serialized packet word
- OUT_VALID  out  1  OUT_DATA valid
- OUT_READY  in  1  consumer accepts word when OUT_VALID & OUT_READY
- OUT_LAST  out  1  high on the fourth word of a packet
- OUT_SRC  out  2  index of the source currently being sent
- PKT_COUNT  out  16  packets fully sent since reset, wraps 16'hFFFF -> 0

## Operation

- States: IDLE, READ, CAPTURE, SEND.
- IDLE:
  - Requires ARB_ENABLE = 1 and at least one source i < NUM_SRC with SRC_FIFO_EMPTY[i] = 0.
  - Selects the first non-empty source scanning from (last_served+1) mod NUM_SRC upward with wrap.
  - Registers the selection into sel and goes to READ.
- READ: SRC_FIFO_READ[sel] = 1 for exactly this cycle; -> CAPTURE.
- CAPTURE: loads SRC_FIFO_DATA[sel] into a 128-bit shift register; sets word index to 0; -> SEND.
- SEND: OUT_VALID = 1. Word order:
  - word 0 = bits 127:96, the packet header
  - word 1 = bits 95:64
  - word 2 = bits 63:32
  - word 3 = bits 31:0, the timestamp
- Index advances only on OUT_VALID & OUT_READY. OUT_LAST = 1 while index = 3.
- On acceptance of word 3:
  - PKT_COUNT increments.
  - last_served <= sel.
  - State returns to IDLE.
- ARB_ENABLE low never aborts a packet already past IDLE; it only blocks the IDLE -> READ transition.
- The block never strobes a source whose empty flag was 1 in the selecting IDLE cycle. SRC_FIFO_READ is never asserted outside READ.
- Selection is never reissued mid-packet. Empty-flag changes during READ, CAPTURE or SEND have no effect on the current packet.
- Packet content is passed through unmodified; no header checking.

## Timing

- Reset values:
  - all SRC_FIFO_READ = 0
  - OUT_VALID = 0, OUT_LAST = 0
  - OUT_DATA = 0, OUT_SRC = 0
  - PKT_COUNT = 0
  - state IDLE, last_served = NUM_SRC-1, so source 0 wins first.
- Latency with OUT_READY held high:
  - IDLE select at cycle n; READ at n+1; CAPTURE at n+2.
  - Words 0..3 appear at n+3..n+6.
  - IDLE again at n+7.
  - Maximum throughput is one packet per 7 cycles.
- FIFO data is sampled in CAPTURE, one cycle after rd_en. This matches a standard-mode FIFO whose dout updates on the edge that samples rd_en.
- Backpressure: while OUT_VALID & !OUT_READY, OUT_DATA, OUT_LAST and OUT_SRC hold stable. Stall length is unbounded.
- OUT_SRC is valid whenever OUT_VALID = 1.
- PKT_COUNT updates on the edge that accepts word 3.
- RESET mid-packet:
  - Packet is dropped; its FIFO entry is already consumed and is lost.
  - Outputs go to reset values asynchronously.
  - No word from that packet is emitted after reset releases.
- NUM_SRC = 1: source 0 is always selected; same cycle timing.

## Test plan

- Single packet:
  - Stimulus: source 0 only non-empty, dout = {32'h1000_3400, 32'hdeadbeef, 32'hdeadbeef, 32'h0000_1234}, OUT_READY = 1.
  - Required: SRC_FIFO_READ = 4'b0001 for one cycle. Words 10003400, deadbeef, deadbeef, 00001234 on four consecutive cycles. OUT_LAST only on the fourth. OUT_SRC = 0. PKT_COUNT = 1.
- Round robin:
  - Stimulus: all four sources hold 2 packets; OUT_READY = 1.
  - Required: OUT_SRC sequence 0,1,2,3,0,1,2,3. PKT_COUNT = 8. Each SRC_FIFO_READ bit pulses exactly twice.
- Backpressure:
  - Stimulus: OUT_READY low for 5 cycles while word 1 is presented, then high.
  - Required: word 1 held stable all 5 cycles, no duplicated or skipped word, packet ends 5 cycles later than unstalled.
- Skip empty:
  - Stimulus: last_served = 1, sources 2 and 3 empty, source 0 non-empty.
  - Required: source 0 selected next; no strobe ever seen on bits 2 or 3.
- Enable gating:
  - Stimulus: ARB_ENABLE dropped during word 2.
  - Required: packet completes. No new READ while low, even with non-empty sources. Resumes one cycle after ARB_ENABLE rises.
- Reset mid-packet:
  - Stimulus: RESET pulsed after word 1 is accepted.
  - Required: OUT_VALID = 0 and PKT_COUNT = 0 immediately. Next emitted packet is the following FIFO entry, starting from source 0 priority.
